video_pixel_unpacker: RTL and testbench

// - Downstream of the DDR AXI read stage: absorbs its 256-bit frame-data writes (buf_wr_en/buf_wr_data)

---
 rtl/video_pixel_unpacker.sv | 216 +++++++++++++++++++++
 tb/tb_video_pixel_unpacker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_pixel_unpacker.sv
// video_pixel_unpacker
// Takes the 256-bit frame words written by the DDR AXI read stage, buffers them in a
// synchronous FIFO, unpacks each word into RGB565 pixels and emits one pixel for each
// active HDMI cycle. processing_wait throttles burst issue upstream, and every rising
// edge of hdmi_vsync flushes the FIFO, the hold register and the sticky flags.
//
// Ports
//   clk              single system/pixel clock
//   rst              asynchronous reset, active-low
//   hdmi_vsync       frame sync, active-high (a rising edge starts a frame)
//   hdmi_de          active-video pixel request
//   buf_wr_en        word write strobe from the read stage
//   buf_wr_data      packed pixels, pixel 0 in [PIX_WIDTH-1:0]
//   processing_wait  1 = read stage should stop issuing bursts
//   pix_valid        pix_data valid, a registered copy of hdmi_de
//   pix_data         output pixel
//   fifo_level       number of words currently stored in the FIFO
//   overflow         sticky: a write was dropped because the FIFO was full
//   underflow        sticky: hdmi_de was high with no pixel available
//
// Build option
//   UNDERFLOW_REPEAT_EN  when defined, an underflow repeats the last emitted pixel.
//                        Otherwise an underflow emits black (0).

module video_pixel_unpacker #(
  parameter int unsigned DQ_WIDTH     = 32,
  parameter int unsigned PIX_WIDTH    = 16,
  parameter int unsigned FIFO_DEPTH   = 64,
  parameter int unsigned AFULL_THRESH = 48
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          hdmi_vsync,
  input  logic                          hdmi_de,
  input  logic                          buf_wr_en,
  input  logic [DQ_WIDTH*8-1:0]         buf_wr_data,
  output logic                          processing_wait,
  output logic                          pix_valid,
  output logic [PIX_WIDTH-1:0]          pix_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int unsigned WORD_W       = DQ_WIDTH * 8;
  localparam int unsigned PIX_PER_WORD = WORD_W / PIX_WIDTH;
  localparam int unsigned ADDR_W       = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W        = ADDR_W + 1;
  localparam int unsigned IDX_W        = $clog2(PIX_PER_WORD);

  typedef enum logic {
    HOLD_EMPTY,
    HOLD_VALID
  } hold_state_e;

  logic [WORD_W-1:0]    mem [FIFO_DEPTH];

  hold_state_e          state_q, state_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WORD_W-1:0]    hold_q, hold_d;
  logic [PIX_WIDTH-1:0] pix_data_q, pix_data_d;
  logic [PIX_WIDTH-1:0] last_pix_q, last_pix_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic                 pix_valid_q;
  logic                 wait_q;
  logic                 vsync_q;

  logic                 frame_start;
  logic [PTR_W-1:0]     level;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 do_write;
  logic                 do_pop;
  logic [WORD_W-1:0]    rd_data;
  logic [PIX_WIDTH-1:0] fill_pix;
  logic [PIX_WIDTH-1:0] pix_arr [PIX_PER_WORD];

  assign frame_start = hdmi_vsync & ~vsync_q;
  assign level       = wr_ptr_q - rd_ptr_q;
  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign fifo_full   = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                       (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  // Fullness is judged before any same-cycle pop, so a full FIFO never accepts a write.
  assign do_write    = buf_wr_en & ~fifo_full & ~frame_start;
  assign rd_data     = mem[rd_ptr_q[ADDR_W-1:0]];

`ifdef UNDERFLOW_REPEAT_EN
  assign fill_pix = last_pix_q;
`else
  assign fill_pix = '0;
`endif

  always_comb begin
    for (int unsigned i = 0; i < PIX_PER_WORD; i++) begin
      pix_arr[i] = hold_q[i*PIX_WIDTH +: PIX_WIDTH];
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    pix_data_d = pix_data_q;
    last_pix_d = last_pix_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    do_pop     = 1'b0;

    if (frame_start) begin
      // The flush wins over everything else in this cycle, including a pixel request.
      state_d    = HOLD_EMPTY;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      idx_d      = '0;
      hold_d     = '0;
      last_pix_d = '0;
      ovf_d      = 1'b0;
      unf_d      = 1'b0;
      if (hdmi_de) begin
        pix_data_d = '0;
      end
    end else begin
      if (buf_wr_en) begin
        if (fifo_full) begin
          ovf_d = 1'b1;
        end else begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
      end

      unique case (state_q)
        HOLD_EMPTY: begin
          if (hdmi_de) begin
            pix_data_d = fill_pix;
            unf_d      = 1'b1;
          end
          if (!fifo_empty) begin
            do_pop = 1'b1;
          end
        end
        HOLD_VALID: begin
          if (hdmi_de) begin
            pix_data_d = pix_arr[idx_q];
            last_pix_d = pix_arr[idx_q];
            idx_d      = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(PIX_PER_WORD - 1)) begin
              // Reload in the same cycle so consecutive words stream without a bubble.
              if (!fifo_empty) begin
                do_pop = 1'b1;
              end else begin
                state_d = HOLD_EMPTY;
              end
            end
          end
        end
        default: state_d = HOLD_EMPTY;
      endcase

      if (do_pop) begin
        hold_d   = rd_data;
        idx_d    = '0;
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        state_d  = HOLD_VALID;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr_q[ADDR_W-1:0]] <= buf_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= HOLD_EMPTY;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      idx_q       <= '0;
      hold_q      <= '0;
      pix_data_q  <= '0;
      last_pix_q  <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      pix_valid_q <= 1'b0;
      wait_q      <= 1'b0;
      vsync_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      pix_data_q  <= pix_data_d;
      last_pix_q  <= last_pix_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      pix_valid_q <= hdmi_de;
      wait_q      <= (level >= PTR_W'(AFULL_THRESH));
      vsync_q     <= hdmi_vsync;
    end
  end

  assign processing_wait = wait_q;
  assign pix_valid       = pix_valid_q;
  assign pix_data        = pix_data_q;
  assign fifo_level      = level;
  assign overflow        = ovf_q;
  assign underflow       = unf_q;

endmodule

// File: tb/tb_video_pixel_unpacker.sv
module tb_video_pixel_unpacker;

  localparam int unsigned WORD_W = 256;

  logic               clk;
  logic               rst;
  logic               hdmi_vsync;
  logic               hdmi_de;
  logic               buf_wr_en;
  logic [WORD_W-1:0]  buf_wr_data;
  logic               processing_wait;
  logic               pix_valid;
  logic [15:0]        pix_data;
  logic [6:0]         fifo_level;
  logic               overflow;
  logic               underflow;

  int unsigned n_pass;
  int unsigned n_total;
  logic [15:0] exp_q [$];

`ifdef UNDERFLOW_REPEAT_EN
  localparam logic [15:0] FILL_AFTER_FIRST = 16'h011F;
`else
  localparam logic [15:0] FILL_AFTER_FIRST = 16'h0000;
`endif

  video_pixel_unpacker #(
    .DQ_WIDTH    (32),
    .PIX_WIDTH   (16),
    .FIFO_DEPTH  (64),
    .AFULL_THRESH(48)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .hdmi_vsync     (hdmi_vsync),
    .hdmi_de        (hdmi_de),
    .buf_wr_en      (buf_wr_en),
    .buf_wr_data    (buf_wr_data),
    .processing_wait(processing_wait),
    .pix_valid      (pix_valid),
    .pix_data       (pix_data),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WORD_W-1:0] mkword(input logic [15:0] base);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      w[i*16 +: 16] = base + 16'(i);
    end
    return w;
  endfunction

  // One clock of stimulus; an expected pixel is queued whenever de is driven.
  task automatic cyc(input logic de, input logic wr, input logic [WORD_W-1:0] d,
                     input logic vs, input logic [15:0] exp);
    hdmi_de     = de;
    buf_wr_en   = wr;
    buf_wr_data = d;
    hdmi_vsync  = vs;
    if (de) exp_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0, 16'h0);
  endtask

  // Scoreboard monitor: every presented pixel is matched against the queue.
  always @(negedge clk) begin
    if (rst && pix_valid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL pix_extra: got %0h expected no pixel (t=%0t)", pix_data, $time);
      end else begin
        check("pix", {16'h0, pix_data}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] lv;
    logic [6:0] prev_lv;
    n_pass = 0;
    n_total = 0;
    rst = 1'b0;
    hdmi_vsync = 1'b0;
    hdmi_de = 1'b0;
    buf_wr_en = 1'b0;
    buf_wr_data = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(pix_valid), 32'd0);
    check("rst_data", 32'(pix_data), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_wait", 32'(processing_wait), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_unf", 32'(underflow), 32'd0);
    rst = 1'b1;
    idle(1);

    // Two words, 32 pixels streamed back-to-back across the word boundary.
    cyc(1'b0, 1'b1, mkword(16'h0100), 1'b0, 16'h0);
    cyc(1'b0, 1'b1, mkword(16'h0110), 1'b0, 16'h0);
    idle(3);
    check("b_level", 32'(fifo_level), 32'd1);
    for (int i = 0; i < 32; i++) cyc(1'b1, 1'b0, '0, 1'b0, 16'h0100 + 16'(i));
    idle(1);
    check("b_unf", 32'(underflow), 32'd0);
    check("b_level_end", 32'(fifo_level), 32'd0);

    // Underflow for three cycles.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, '0, 1'b0, FILL_AFTER_FIRST);
    idle(1);
    check("c_unf", 32'(underflow), 32'd1);

    // Frame start clears the sticky flag.
    cyc(1'b0, 1'b0, '0, 1'b1, 16'h0);
    cyc(1'b0, 1'b0, '0, 1'b0, 16'h0);
    check("d_unf_clr", 32'(underflow), 32'd0);

    // Fill: the first word goes to the hold register, the next 64 fill the FIFO.
    prev_lv = 7'd0;
    for (int n = 0; n < 65; n++) begin
      cyc(1'b0, 1'b1, mkword(16'h2000 + 16'(n * 16)), 1'b0, 16'h0);
      lv = (n == 0) ? 7'd1 : 7'(n);
      check("e_level", 32'(fifo_level), 32'(lv));
      check("e_wait", 32'(processing_wait), 32'(prev_lv >= 7'd48));
      prev_lv = lv;
    end
    check("e_ovf_pre", 32'(overflow), 32'd0);
    cyc(1'b0, 1'b1, {16{16'hDEAD}}, 1'b0, 16'h0);
    check("e_full_level", 32'(fifo_level), 32'd64);
    check("e_ovf", 32'(overflow), 32'd1);
    check("e_wait_full", 32'(processing_wait), 32'd1);
    for (int i = 0; i < 32; i++) cyc(1'b1, 1'b0, '0, 1'b0, 16'h2000 + 16'(i));
    idle(1);
    check("e_level_drain", 32'(fifo_level), 32'd62);
    check("e_ovf_sticky", 32'(overflow), 32'd1);

    // Frame start with de high and a write in the same cycle: flush wins, pixel is 0.
    cyc(1'b1, 1'b1, {16{16'hBEEF}}, 1'b1, 16'h0000);
    check("f_level0", 32'(fifo_level), 32'd0);
    check("f_ovf_clr", 32'(overflow), 32'd0);
    check("f_unf_clr", 32'(underflow), 32'd0);
    cyc(1'b1, 1'b0, '0, 1'b0, 16'h0000);
    idle(1);
    check("f_unf", 32'(underflow), 32'd1);
    check("f_wait_clr", 32'(processing_wait), 32'd0);

    // Load ten old-frame words, then flush them with a new frame start.
    for (int n = 0; n < 10; n++) cyc(1'b0, 1'b1, mkword(16'h6000 + 16'(n * 16)), 1'b0, 16'h0);
    idle(2);
    check("f_level9", 32'(fifo_level), 32'd9);
    cyc(1'b0, 1'b1, {16{16'hBAD0}}, 1'b1, 16'h0);
    check("f2_level0", 32'(fifo_level), 32'd0);
    check("f2_unf_clr", 32'(underflow), 32'd0);
    idle(1);

    // Write during a word-boundary pop at level 1; stream must stay seamless.
    cyc(1'b0, 1'b1, mkword(16'h7000), 1'b0, 16'h0);
    cyc(1'b0, 1'b1, mkword(16'h7010), 1'b0, 16'h0);
    idle(2);
    check("g_level1", 32'(fifo_level), 32'd1);
    for (int j = 0; j < 48; j++) begin
      cyc(1'b1, (j == 15), mkword(16'h7020), 1'b0, 16'h7000 + 16'(j));
      if (j == 15) check("g_level_same", 32'(fifo_level), 32'd1);
    end
    idle(2);
    check("g_level_end", 32'(fifo_level), 32'd0);
    check("g_unf", 32'(underflow), 32'd0);

    // Reset mid-stream at level 20, index 7.
    for (int n = 0; n < 21; n++) cyc(1'b0, 1'b1, mkword(16'h8000 + 16'(n * 16)), 1'b0, 16'h0);
    idle(2);
    check("h_level20", 32'(fifo_level), 32'd20);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, '0, 1'b0, 16'h8000 + 16'(i));
    idle(2);
    check("h_last_pix", 32'(pix_data), 32'h8006);
    rst = 1'b0;
    #1;
    check("h_rst_valid", 32'(pix_valid), 32'd0);
    check("h_rst_data", 32'(pix_data), 32'd0);
    check("h_rst_level", 32'(fifo_level), 32'd0);
    check("h_rst_wait", 32'(processing_wait), 32'd0);
    check("h_rst_ovf", 32'(overflow), 32'd0);
    check("h_rst_unf", 32'(underflow), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1);
    cyc(1'b0, 1'b1, mkword(16'h9000), 1'b0, 16'h0);
    idle(2);
    check("h_level_hold", 32'(fifo_level), 32'd0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, '0, 1'b0, 16'h9000 + 16'(i));
    idle(3);
    check("h_unf", 32'(underflow), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
